// File: rtl/pulse_generator.sv
// pulse_generator: emits a programmable train of N pulses on o_oc_pin with
// programmable high/low widths (in sysclk cycles), flagging each completed
// pulse and keeping a running pulse count.
// Optional build macro: PULSEGEN_CONT_EN -- a start with i_pulse_num=0 runs
// pulses continuously until i_stop or reset (count wraps, no o_done).
module pulse_generator #(
  parameter int CNT_W = 16,
  parameter int LEN_W = 16
) (
  input  logic             i_sysclk,
  input  logic             i_sysrst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [CNT_W-1:0] i_pulse_num,
  input  logic [LEN_W-1:0] i_high_len,
  input  logic [LEN_W-1:0] i_low_len,
  output logic             o_oc_pin,
  output logic             o_busy,
  output logic             o_oc_flg,
  output logic             o_done,
  output logic [CNT_W-1:0] o_pulse_cnt
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] ph;        // cycles remaining in the current phase, minus one
  logic [LEN_W-1:0] high_len;  // latched max(i_high_len,1)
  logic [LEN_W-1:0] low_len;   // latched max(i_low_len,1)
  logic [CNT_W-1:0] rem;       // pulses not yet completed
  logic             stop_pend; // stop seen on the last high cycle; abort after the flag cycle
  logic             start_ok;
  logic             last_pulse;

`ifdef PULSEGEN_CONT_EN
  logic cont;

  // Zero pulse count selects continuous mode; the train never runs out
  always_comb begin
    start_ok   = i_start && !i_stop;
    last_pulse = (rem == '0) && !cont;
  end
`else
  // Zero pulse count is simply not a valid start
  always_comb begin
    start_ok   = i_start && !i_stop && (i_pulse_num != '0);
    last_pulse = (rem == '0);
  end
`endif

  // Train sequencer with registered outputs
  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      state       <= IDLE;
      ph          <= '0;
      high_len    <= '0;
      low_len     <= '0;
      rem         <= '0;
      stop_pend   <= 1'b0;
      o_oc_pin    <= 1'b0;
      o_busy      <= 1'b0;
      o_oc_flg    <= 1'b0;
      o_done      <= 1'b0;
      o_pulse_cnt <= '0;
`ifdef PULSEGEN_CONT_EN
      cont        <= 1'b0;
`endif
    end else begin
      o_oc_flg <= 1'b0;
      o_done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            state       <= HIGH;
            high_len    <= (i_high_len == '0) ? LEN_ONE : i_high_len;
            low_len     <= (i_low_len  == '0) ? LEN_ONE : i_low_len;
            ph          <= (i_high_len == '0) ? '0 : i_high_len - LEN_ONE;
            rem         <= i_pulse_num;
            stop_pend   <= 1'b0;
            o_pulse_cnt <= '0;
            o_oc_pin    <= 1'b1;
            o_busy      <= 1'b1;
`ifdef PULSEGEN_CONT_EN
            cont        <= (i_pulse_num == '0);
`endif
          end
        end
        HIGH: begin
          if (ph == '0) begin
            // High phase complete: the pulse counts even if stop arrives now
            state       <= LOW;
            ph          <= low_len - LEN_ONE;
            rem         <= rem - CNT_ONE;
            stop_pend   <= i_stop;
            o_pulse_cnt <= o_pulse_cnt + CNT_ONE;
            o_oc_flg    <= 1'b1;
            o_oc_pin    <= 1'b0;
          end else if (i_stop) begin
            state    <= IDLE;
            o_oc_pin <= 1'b0;
            o_busy   <= 1'b0;
          end else begin
            ph <= ph - LEN_ONE;
          end
        end
        LOW: begin
          if (i_stop || stop_pend) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
            o_busy    <= 1'b0;
          end else if (ph != '0) begin
            ph <= ph - LEN_ONE;
          end else if (last_pulse) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else begin
            state    <= HIGH;
            ph       <= high_len - LEN_ONE;
            o_oc_pin <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_generator.sv
// tb_pulse_generator: drives directed and random pulse trains and compares
// every cycle of pin/busy/flag/done/count against a timing model derived
// from the train formula (pulse index and phase offset by division).
module tb_pulse_generator;
  localparam int CW = 16;
  localparam int LW = 16;

  logic          i_sysclk = 1'b0;
  logic          i_sysrst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_stop = 1'b0;
  logic [CW-1:0] i_pulse_num = '0;
  logic [LW-1:0] i_high_len = '0;
  logic [LW-1:0] i_low_len = '0;
  logic          o_oc_pin, o_busy, o_oc_flg, o_done;
  logic [CW-1:0] o_pulse_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int last_cnt = 0;

  pulse_generator #(.CNT_W(CW), .LEN_W(LW)) dut (
    .i_sysclk(i_sysclk), .i_sysrst(i_sysrst), .i_start(i_start), .i_stop(i_stop),
    .i_pulse_num(i_pulse_num), .i_high_len(i_high_len), .i_low_len(i_low_len),
    .o_oc_pin(o_oc_pin), .o_busy(o_busy), .o_oc_flg(o_oc_flg), .o_done(o_done),
    .o_pulse_cnt(o_pulse_cnt)
  );

  always #5 i_sysclk = ~i_sysclk;

  // Expected {pin,busy,flg,done,cnt} for cycle k after a start at cycle 0,
  // with an optional stop driven during cycle stop_at (0 = none).
  function automatic logic [CW+3:0] model(int k, int n, int h, int l, int stop_at);
    int hp, lp, p, t, eff, rel, off, rs;
    hp = (h == 0) ? 1 : h;
    lp = (l == 0) ? 1 : l;
    p = hp + lp;
    t = n * p;
    eff = 1 << 30;
    if (stop_at > 0 && stop_at <= t) begin
      rs = stop_at - 1;
      eff = ((rs % p) == hp - 1) ? stop_at + 1 : stop_at;
    end
    if (k > eff) begin
      rel = eff - 1;
      off = rel % p;
      return {4'b0000, CW'(rel / p + ((off >= hp) ? 1 : 0))};
    end
    rel = k - 1;
    if (rel < t) begin
      off = rel % p;
      return {off < hp, 1'b1, off == hp, 1'b0, CW'(rel / p + ((off >= hp) ? 1 : 0))};
    end
    if (rel == t) return {4'b0001, CW'(n)};
    return {4'b0000, CW'(n)};
  endfunction

  // One train from the current negedge; poke_k injects a stray start mid-train
  task automatic run_train(input string name, input int n, input int h, input int l,
                           input int stop_at, input int poke_k);
    int t;
    logic [CW+3:0] got, exp;
    t = n * (((h == 0) ? 1 : h) + ((l == 0) ? 1 : l));
    i_start = 1'b1; i_stop = 1'b0;
    i_pulse_num = CW'(n); i_high_len = LW'(h); i_low_len = LW'(l);
    for (int k = 1; k <= t + 3; k++) begin
      @(negedge i_sysclk);
      got = {o_oc_pin, o_busy, o_oc_flg, o_done, o_pulse_cnt};
      exp = model(k, n, h, l, stop_at);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL %s cycle=%0d got pin/busy/flg/done/cnt=%h expected=%h", name, k, got, exp);
      end
      i_start = (k == poke_k);
      i_stop = (k == stop_at);
      i_pulse_num = CW'($urandom_range(1, 7));
      i_high_len = LW'($urandom_range(0, 6));
      i_low_len = LW'($urandom_range(0, 6));
    end
    i_start = 1'b0; i_stop = 1'b0;
    last_cnt = int'(model(t + 100, n, h, l, stop_at)) & 16'hFFFF;
  endtask

  // Idle for a few cycles after a start that must be rejected
  task automatic expect_idle(input string name, input int cycles);
    logic [CW+3:0] got, exp;
    exp = {4'b0000, CW'(last_cnt)};
    for (int k = 1; k <= cycles; k++) begin
      @(negedge i_sysclk);
      i_start = 1'b0; i_stop = 1'b0;
      got = {o_oc_pin, o_busy, o_oc_flg, o_done, o_pulse_cnt};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL %s cycle=%0d got=%h expected=%h", name, k, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic [CW+3:0] got;
    got = {o_oc_pin, o_busy, o_oc_flg, o_done, o_pulse_cnt};
    n_checks++;
    if (got !== '0) begin
      n_errors++;
      $display("FAIL reset_state got=%h expected=0", got);
    end
    @(negedge i_sysclk);
    i_sysrst = 1'b0;
    expect_idle("reset_idle", 2);
  endtask

  task automatic test_directed();
    run_train("basic", 3, 2, 3, 0, 0);
    run_train("zero_len", 2, 0, 0, 0, 0);
    run_train("abort", 5, 4, 4, 10, 0);
    run_train("stop_at_flag", 3, 3, 2, 8, 0);
    run_train("stop_last_low", 2, 1, 2, 6, 0);
    run_train("mid_start", 3, 2, 2, 0, 4);
  endtask

  task automatic test_ignored_starts();
`ifndef PULSEGEN_CONT_EN
    i_start = 1'b1; i_stop = 1'b0; i_pulse_num = '0; i_high_len = 3; i_low_len = 3;
    expect_idle("zero_num", 5);
`endif
    i_start = 1'b1; i_stop = 1'b1; i_pulse_num = 4; i_high_len = 2; i_low_len = 2;
    expect_idle("start_stop", 5);
  endtask

  task automatic test_async_reset();
    logic [CW+3:0] got;
    run_train("pre_reset", 1, 1, 1, 0, 0);
    i_start = 1'b1; i_pulse_num = 3; i_high_len = 4; i_low_len = 2;
    @(negedge i_sysclk);
    i_start = 1'b0;
    @(negedge i_sysclk);
    @(negedge i_sysclk);
    #1 i_sysrst = 1'b1;
    #1 got = {o_oc_pin, o_busy, o_oc_flg, o_done, o_pulse_cnt};
    n_checks++;
    if (got !== '0) begin
      n_errors++;
      $display("FAIL async_reset got=%h expected=0", got);
    end
    @(negedge i_sysclk);
    i_sysrst = 1'b0;
    last_cnt = 0;
    expect_idle("post_reset_idle", 1);
    run_train("after_reset", 3, 4, 2, 0, 0);
  endtask

  task automatic test_random();
    int n, h, l, t, hp, stop_at, poke, eff;
    for (int i = 0; i < 30; i++) begin
      n = $urandom_range(1, 4);
      h = $urandom_range(0, 4);
      l = $urandom_range(0, 4);
      hp = (h == 0) ? 1 : h;
      t = n * (hp + ((l == 0) ? 1 : l));
      stop_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, t + 1) : 0;
      eff = t;
      if (stop_at > 0 && stop_at < eff) eff = stop_at;
      poke = ($urandom_range(0, 1) == 1) ? $urandom_range(1, eff) : 0;
      run_train("random", n, h, l, stop_at, poke);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_directed();
    test_ignored_starts();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pulse_generator.md
Name: pulse_generator

Overview:
- Output-side counterpart of the input capture counter: drives a pin instead of counting edges on one.
- Emits a programmable train of N pulses on o_oc_pin, with programmable high and low widths in sysclk cycles.
- Reports each completed pulse with a one-cycle flag and a running 16-bit pulse count. Sits beside the capture block in the counter peripheral.

Parameters:
CNT_W, 16, width of the pulse-number input and the o_pulse_cnt output
LEN_W, 16, width of the high/low length inputs and the internal phase counter

Ports:
i_sysclk  in  1  system clock; all logic on rising edge
i_sysrst  in  1  system reset, asynchronous, active-high
i_start  in  1  start request; single-cycle or level, sampled only in IDLE
i_stop  in  1  abort request; sampled every cycle
i_pulse_num  in  CNT_W  number of pulses to emit
i_high_len  in  LEN_W  high phase length in cycles; 0 treated as 1
i_low_len  in  LEN_W  low phase length in cycles; 0 treated as 1
o_oc_pin  out  1  registered pulse output
o_busy  out  1  high while a train is in progress (HIGH or LOW state)
o_oc_flg  out  1  one-cycle flag on the first low cycle of each completed pulse
o_done  out  1  one-cycle flag after the last pulse's low phase ends
o_pulse_cnt  out  CNT_W  pulses completed in the current/last train

Behaviour:
- Interface: one clock, i_sysclk; reset i_sysrst is asynchronous and active-high.
- Reset: FSM=IDLE; all outputs 0; o_pulse_cnt=0; internal counters 0. Reset mid-train drops the pin low immediately and sets no flag.
- States: IDLE, HIGH, LOW, DONE. All outputs are registered.
- IDLE:
  - Transition: i_start=1 and i_stop=0 and i_pulse_num!=0 -> HIGH.
  - Latches i_pulse_num, max(i_high_len,1) and max(i_low_len,1); clears o_pulse_cnt.
  - Inputs may change freely after the start cycle.
- Start with i_pulse_num=0: ignored; stays IDLE; no o_done.
- Start cycle t: o_oc_pin=1 and o_busy=1 from cycle t+1.
- HIGH: lasts H cycles, then -> LOW.
- First LOW cycle: o_oc_pin=0; o_oc_flg=1 for that cycle only; o_pulse_cnt increments in the same cycle.
- LOW: lasts L cycles.
  - If pulses remain -> HIGH.
  - Else -> DONE. The trailing low gap of the last pulse is always included.
- DONE: one cycle; o_done=1, o_busy=0; then -> IDLE.
- Total busy time: N*(H+L) cycles. o_done is asserted at cycle t+1+N*(H+L).
- i_start while busy or in DONE: ignored.
- i_stop in HIGH or LOW:
  - Next cycle: FSM=IDLE, pin=0, busy=0.
  - No o_oc_flg for a truncated high phase; no o_done.
  - o_pulse_cnt holds the completed count.
- i_stop coincident with the first-LOW-cycle transition: the completed pulse is still flagged and counted; abort takes effect the following cycle.
- i_start and i_stop together in IDLE: stop wins; no start.
- o_pulse_cnt holds its value after DONE until the next accepted start.
- Without the optional feature, o_pulse_cnt never wraps (N <= 2^CNT_W-1).

Optional Feature:
- Macro PULSEGEN_CONT_EN.
- Defined: i_pulse_num=0 at start selects continuous mode.
  - Emits pulses indefinitely until i_stop or reset.
  - o_pulse_cnt wraps 0xFFFF -> 0x0000; o_oc_flg continues per pulse.
  - o_done is never asserted in this mode.
  - Nonzero i_pulse_num behaves as the base design.
- Undefined: i_pulse_num=0 start is ignored as described above; no continuous-mode logic is synthesised.

Test Plan:
- Basic train: N=3, H=2, L=3, start at cycle 0 -> pin high 1-2, 6-7, 11-12; o_oc_flg at 3, 8, 13; busy 1-15; o_done at 16; o_pulse_cnt=3.
- Zero lengths: N=2, H=0, L=0 -> behaves as H=1, L=1: pin 1,0,1,0 on cycles 1-4; done at cycle 5; cnt=2.
- Abort: N=5, H=4, L=4, i_stop at cycle 10 (second high phase) -> pin low at 11, busy low at 11, no done; cnt=1; no flag for the truncated pulse.
- Ignored starts: N=0 start -> stays IDLE, no done; start+stop same cycle -> no activity; start pulsed mid-train -> no restart, counts unaffected.
- Async reset asserted mid-HIGH -> pin, busy, flags and cnt go to 0 without a clock edge; next start runs a full train.
- PULSEGEN_CONT_EN: N=0, H=1, L=1, preload run past 65536 pulses -> cnt wraps to 0 with flags continuing; stop ends the train with no done.
